// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: launch FSM encoding,
// Encoder acknowledge timeout and default buffer depth.
package uart_pkg;

    localparam int DEFAULT_DEPTH = 16;

    // Cycles spent waiting for the Encoder to raise busy before a strobe
    // is treated as accepted anyway.
    localparam int ACK_TIMEOUT = 4;
    localparam int ACK_CNT_W   = $clog2(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        ACK,
        DRAIN
    } tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte-wide register array with synchronous write and combinational read.
// Pointer and occupancy tracking live in the owner so the same storage can
// sit behind either the transmit or the receive path.
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem_q [DEPTH];

    // Store one byte per cycle; contents need no reset because the owner's
    // count decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer in front of the UART Encoder: accepts CPU bytes at core
// speed and hands them to the Encoder one frame at a time with a one-cycle
// launch strobe, flagging the byte that empties the queue.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          flush,
    input  logic          ovf_clr,
    input  logic          enc_busy,
    output logic          enc_wr,
    output logic [7:0]    enc_data,
    output logic          enc_last,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow
);

    localparam logic [AW:0]        CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]        CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0]      PTR_ONE   = AW'(1);
    localparam logic [ACK_CNT_W-1:0] ACK_LAST = ACK_CNT_W'(ACK_TIMEOUT - 1);

    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic                 overflow_q, overflow_d;
    tx_state_e            state_q, state_d;
    logic [ACK_CNT_W-1:0] ack_cnt_q, ack_cnt_d;
    logic                 enc_wr_q, enc_wr_d;
    logic [7:0]           enc_data_q, enc_data_d;

    logic                 full_w;
    logic                 empty_w;
    logic                 push_ok;
    logic                 push_drop;
    logic                 pop;
    logic [7:0]           head_byte;

    assign full_w    = (count_q == CNT_FULL);
    assign empty_w   = (count_q == '0);
    // Fullness is judged before any pop in the same cycle, and flush
    // swallows a simultaneous push without counting it as an overflow.
    assign push_ok   = wr_en && !full_w && !flush;
    assign push_drop = wr_en &&  full_w && !flush;
    assign pop       = (state_q == LAUNCH) && !flush;

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (push_ok),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_data),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (head_byte)
    );

    // Pointer, occupancy and sticky overflow bookkeeping.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push_ok, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        if (push_drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    // Launch handshake: present the head byte, then wait for the Encoder to
    // take it (or time out) and finish its frame before the next launch.
    always_comb begin
        state_d    = state_q;
        ack_cnt_d  = '0;
        enc_wr_d   = 1'b0;
        enc_data_d = enc_data_q;

        case (state_q)
            IDLE: begin
                if (!empty_w && !enc_busy && !flush) begin
                    state_d    = LAUNCH;
                    enc_wr_d   = 1'b1;
                    enc_data_d = head_byte;
                end
            end
            LAUNCH: begin
                state_d = ACK;
            end
            ACK: begin
                if (enc_busy) begin
                    state_d = DRAIN;
                end else if (ack_cnt_q == ACK_LAST) begin
                    state_d = IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q + ACK_CNT_W'(1);
                end
            end
            DRAIN: begin
                if (!enc_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            ack_cnt_q  <= '0;
            enc_wr_q   <= 1'b0;
            enc_data_q <= 8'h00;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            ack_cnt_q  <= ack_cnt_d;
            enc_wr_q   <= enc_wr_d;
            enc_data_q <= enc_data_d;
        end
    end

    assign enc_wr   = enc_wr_q;
    assign enc_data = enc_data_q;
    // The launched byte is the last one only if nothing arrives behind it
    // during the launch cycle itself.
    assign enc_last = enc_wr_q && (count_q == CNT_ONE) && !push_ok;
    assign full     = full_w;
    assign empty    = empty_w;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple Encoder model and a
// scoreboard of bytes expected on the launch strobe.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       ovf_clr;
    logic       enc_busy;
    logic       enc_wr;
    logic [7:0] enc_data;
    logic       enc_last;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t expQ[$];

    int checkCount = 0;
    int passCount  = 0;
    int launchCount = 0;
    int cycleCnt = 0;
    int lastLaunchCycle = 0;
    int prevLaunchCycle = 0;
    int base = 0;

    // Encoder model controls
    logic forceBusy = 1'b0;
    logic neverBusy = 1'b0;
    int   frameLen  = 4340;
    int   busyCnt   = 0;
    logic prevEncWr = 1'b0;

    uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .flush    (flush),
        .ovf_clr  (ovf_clr),
        .enc_busy (enc_busy),
        .enc_wr   (enc_wr),
        .enc_data (enc_data),
        .enc_last (enc_last),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Encoder: busy for frameLen cycles starting the cycle after a strobe.
    always @(posedge clk) begin
        if (rst) busyCnt <= 0;
        else if (enc_wr && !neverBusy) busyCnt <= frameLen;
        else if (busyCnt > 0) busyCnt <= busyCnt - 1;
    end

    assign enc_busy = forceBusy | (busyCnt != 0);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Launch monitor: every strobe is scored against the expected queue.
    always @(negedge clk) begin
        if (!rst && enc_wr) begin
            exp_t e;
            prevLaunchCycle = lastLaunchCycle;
            lastLaunchCycle = cycleCnt;
            launchCount++;
            checkOutput("enc_wr_pulse_width", prevEncWr, 1'b0);
            checkOutput("enc_wr_while_busy", enc_busy, 1'b0);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_enc_wr", enc_wr, 1'b0);
            end else begin
                e = expQ.pop_front();
                checkOutput("enc_data", enc_data, e.data);
                checkOutput("enc_last", enc_last, e.last);
            end
        end
        prevEncWr = enc_wr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [7:0] d, input logic fl, input logic oc);
        wr_en   = we;
        wr_data = d;
        flush   = fl;
        ovf_clr = oc;
        tick();
        wr_en   = 1'b0;
        wr_data = 8'h00;
        flush   = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic expectLaunch(input logic [7:0] d, input logic last);
        exp_t e;
        e.data = d;
        e.last = last;
        expQ.push_back(e);
    endtask

    task automatic waitLaunches(input int target, input int bound, input string tag);
        for (int n = 0; n < bound && launchCount < target; n++) tick();
        checkOutput(tag, launchCount, target);
    endtask

    task automatic waitBusy(input logic level, input int bound, input string tag);
        for (int n = 0; n < bound && enc_busy !== level; n++) tick();
        checkOutput(tag, enc_busy, level);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_count"}, count, 0);
        checkOutput({tag, "_empty"}, empty, 1'b1);
        checkOutput({tag, "_full"}, full, 1'b0);
        checkOutput({tag, "_overflow"}, overflow, 1'b0);
        checkOutput({tag, "_enc_wr"}, enc_wr, 1'b0);
        checkOutput({tag, "_enc_data"}, enc_data, 8'h00);
        checkOutput({tag, "_enc_last"}, enc_last, 1'b0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; ovf_clr = 1'b0;
        tick();
        tick();
        checkResetValues("reset");
        rst = 1'b0;
        tick();

        // Burst of four bytes into a slow Encoder
        $display("[TB] burst push");
        frameLen = 4340;
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0); expectLaunch(8'h55, 1'b0);
        checkOutput("burst_count1", count, 1);
        checkOutput("burst_no_early_wr", enc_wr, 1'b0);
        applyStimulus(1'b1, 8'hB0, 1'b0, 1'b0); expectLaunch(8'hB0, 1'b0);
        checkOutput("burst_count2", count, 2);
        checkOutput("burst_latency_wr", enc_wr, 1'b1);
        applyStimulus(1'b1, 8'hE1, 1'b0, 1'b0); expectLaunch(8'hE1, 1'b0);
        checkOutput("burst_count_pushpop", count, 2);
        applyStimulus(1'b1, 8'hAD, 1'b0, 1'b0); expectLaunch(8'hAD, 1'b1);
        checkOutput("burst_count3", count, 3);
        waitLaunches(4, 4 * 4400, "burst_launches");
        tick();
        checkOutput("burst_empty", empty, 1'b1);
        checkOutput("burst_count0", count, 0);
        waitBusy(1'b0, 5000, "burst_frame_end");
        repeat (3) tick();

        // Fill to full, overflow, then launch from a full FIFO
        $display("[TB] fill and overflow");
        frameLen = 20;
        forceBusy = 1'b1;
        base = launchCount;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
            expectLaunch(8'(i), i == 15);
        end
        checkOutput("fill_full", full, 1'b1);
        checkOutput("fill_count16", count, 16);
        checkOutput("fill_no_ovf", overflow, 1'b0);
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
        checkOutput("drop_ovf_set", overflow, 1'b1);
        checkOutput("drop_count16", count, 16);
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b1);
        checkOutput("ovf_set_wins", overflow, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("ovf_clr", overflow, 1'b0);
        forceBusy = 1'b0;
        tick();
        checkOutput("full_launch_wr", enc_wr, 1'b1);
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
        checkOutput("launch_drop_ovf", overflow, 1'b1);
        checkOutput("launch_drop_count15", count, 15);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("launch_ovf_clr", overflow, 1'b0);
        waitLaunches(base + 2, 60, "b2b_second_launch");
        checkOutput("b2b_gap", lastLaunchCycle - prevLaunchCycle, 23);
        waitLaunches(base + 16, 16 * 30, "fill_all_launched");
        waitBusy(1'b0, 40, "fill_frame_end");
        repeat (3) tick();
        checkOutput("fill_drained_empty", empty, 1'b1);
        checkOutput("fill_queue_consumed", expQ.size(), 0);

        // Flush while the first byte is in flight
        $display("[TB] flush during drain");
        frameLen = 30;
        base = launchCount;
        applyStimulus(1'b1, 8'hA0, 1'b0, 1'b0); expectLaunch(8'hA0, 1'b0);
        for (int i = 1; i < 5; i++) applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
        waitBusy(1'b1, 10, "flush_in_drain");
        tick();
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
        checkOutput("flush_count0", count, 0);
        checkOutput("flush_empty", empty, 1'b1);
        checkOutput("flush_push_no_ovf", overflow, 1'b0);
        repeat (60) tick();
        checkOutput("flush_single_launch", launchCount, base + 1);
        checkOutput("flush_frame_done", enc_busy, 1'b0);

        // Encoder that never acknowledges
        $display("[TB] ack timeout");
        neverBusy = 1'b1;
        base = launchCount;
        applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0); expectLaunch(8'hC1, 1'b0);
        applyStimulus(1'b1, 8'hC2, 1'b0, 1'b0); expectLaunch(8'hC2, 1'b1);
        waitLaunches(base + 2, 40, "timeout_launches");
        checkOutput("timeout_gap", lastLaunchCycle - prevLaunchCycle, 6);
        repeat (8) tick();
        checkOutput("hold_enc_data", enc_data, 8'hC2);
        checkOutput("hold_enc_last", enc_last, 1'b0);
        checkOutput("timeout_empty", empty, 1'b1);
        neverBusy = 1'b0;

        // Reset in the middle of a frame with bytes still queued
        $display("[TB] reset during drain");
        frameLen = 30;
        base = launchCount;
        applyStimulus(1'b1, 8'hD0, 1'b0, 1'b0); expectLaunch(8'hD0, 1'b0);
        applyStimulus(1'b1, 8'hD1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hD2, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hD3, 1'b0, 1'b0);
        checkOutput("pre_reset_count3", count, 3);
        waitBusy(1'b1, 10, "reset_in_drain");
        tick();
        rst = 1'b1;
        tick();
        checkResetValues("midreset");
        rst = 1'b0;
        repeat (50) tick();
        checkOutput("post_reset_no_launch", launchCount, base + 1);
        checkOutput("post_reset_count0", count, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
